controle_da_ula: RTL and testbench

ALU control unit for the nRISC datapath. It translates the main control's 2-bit `ALUOp` and the instruction's function fields (`z1`, `fv`, `funct`, `z2`) into the 3-bit operation select driven to the ALU. The output is registered and updates once per clock. It also flags field combinations that do not map to a legal operation.

---
 rtl/controle_da_ula.sv | 87 ++++++++
 tb/tb_controle_da_ula.sv | 136 +++++++++++++
 2 files changed

// File: rtl/controle_da_ula.sv
// nRISC ALU control: decodes ALUOp plus the instruction function fields into a registered 3-bit ALU select.
// Define ALU_ILLEGAL_CHECK_EN to enable z1/z2 checking and the illegal flag (otherwise illegal is tied low).
module controle_da_ula (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] z1,
  input  logic [2:0] fv,
  input  logic [2:0] funct,
  input  logic [2:0] z2,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUcontrol,
  output logic       illegal
);

`ifdef ALU_ILLEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [2:0] next_ctrl;
  logic       next_illegal;

  always_comb begin
    next_ctrl    = OP_ADD;
    next_illegal = 1'b0;
    case (ALUOp)
      2'b00: next_ctrl = OP_ADD;
      2'b01: next_ctrl = OP_SUB;
      2'b10: begin
        case (funct)
          3'b000:  next_ctrl = OP_ADD;
          3'b001:  next_ctrl = OP_SUB;
          3'b010:  next_ctrl = OP_AND;
          3'b011:  next_ctrl = OP_OR;
          3'b100:  next_ctrl = OP_SLT;
          3'b101:  next_ctrl = OP_XOR;
          3'b110:  next_ctrl = OP_NOR;
          default: next_ctrl = OP_SHL;
        endcase
        // Malformed R-type falls back to ADD so the datapath stays benign.
        if (CHECK_EN && ((z1 != 3'b000) || (z2 != 3'b000))) begin
          next_ctrl    = OP_ADD;
          next_illegal = 1'b1;
        end
      end
      2'b11: begin
        case (fv)
          3'b000: next_ctrl = OP_ADD;
          3'b001: next_ctrl = OP_AND;
          3'b010: next_ctrl = OP_OR;
          3'b011: next_ctrl = OP_SLT;
          3'b100: next_ctrl = OP_XOR;
          3'b101: next_ctrl = OP_SHL;
          default: begin
            next_ctrl    = OP_ADD;
            next_illegal = CHECK_EN;
          end
        endcase
      end
      default: begin
        next_ctrl    = OP_ADD;
        next_illegal = CHECK_EN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUcontrol <= OP_ADD;
      illegal    <= 1'b0;
    end else begin
      ALUcontrol <= next_ctrl;
      illegal    <= next_illegal;
    end
  end

endmodule

// File: tb/tb_controle_da_ula.sv
// Self-checking bench for controle_da_ula: directed sweeps, async reset and randomized decode against a table model.
module tb_controle_da_ula;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] z1, fv, funct, z2;
  logic [1:0] ALUOp;
  logic [2:0] ALUcontrol;
  logic       illegal;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ALU_ILLEGAL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Operation codes listed by funct / fv value.
  localparam logic [2:0] RMAP [8] = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd7, 3'd3, 3'd4, 3'd5};
  localparam logic [2:0] IMAP [8] = '{3'd2, 3'd0, 3'd1, 3'd7, 3'd3, 3'd5, 3'd2, 3'd2};

  always #5 clk = ~clk;

  controle_da_ula dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .z1         (z1),
    .fv         (fv),
    .funct      (funct),
    .z2         (z2),
    .ALUOp      (ALUOp),
    .ALUcontrol (ALUcontrol),
    .illegal    (illegal)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got illegal/ctrl=%h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic [1:0] op, input logic [2:0] a, input logic [2:0] v,
                                       input logic [2:0] f, input logic [2:0] b);
    case (op)
      2'd0: return {1'b0, 3'd2};
      2'd1: return {1'b0, 3'd6};
      2'd2: begin
        if (CHK && (a != 0 || b != 0)) return {1'b1, 3'd2};
        return {1'b0, RMAP[f]};
      end
      default: return {(CHK && v >= 3'd6), IMAP[v]};
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic [2:0] a, input logic [2:0] v,
                       input logic [2:0] f, input logic [2:0] b);
    ALUOp = op; z1 = a; fv = v; funct = f; z2 = b;
  endtask

  task automatic drive_rand();
    drive(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
  endtask

  // Drive at the falling edge, check one cycle later just after the rising edge.
  task automatic step(input string tag, input logic [1:0] op, input logic [2:0] a, input logic [2:0] v,
                      input logic [2:0] f, input logic [2:0] b);
    logic [3:0] exp;
    @(negedge clk);
    drive(op, a, v, f, b);
    exp = model(op, a, v, f, b);
    @(posedge clk);
    #1 check(tag, {illegal, ALUcontrol}, exp);
  endtask

  initial begin
    logic [3:0] exp;
    rst_n = 1'b1;
    drive_rand();
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", {illegal, ALUcontrol}, 4'h2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_rand();
      @(posedge clk);
      #1 check("reset_hold", {illegal, ALUcontrol}, 4'h2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, 3'd0, 3'd0, 3'd0, 3'd0);
    @(posedge clk);
    #1 check("reset_release_sub", {illegal, ALUcontrol}, 4'h6);

    step("aluop00", 2'b00, 3'd0, 3'd5, 3'd1, 3'd0);
    step("aluop01", 2'b01, 3'd0, 3'd5, 3'd1, 3'd0);
    step("aluop10", 2'b10, 3'd0, 3'd5, 3'd1, 3'd0);
    step("aluop11", 2'b11, 3'd0, 3'd5, 3'd1, 3'd0);

    for (int f = 0; f < 8; f++) step("funct_sweep", 2'b10, 3'd0, 3'($urandom), 3'(f), 3'd0);
    for (int v = 0; v < 8; v++) step("fv_sweep", 2'b11, 3'($urandom), 3'(v), 3'($urandom), 3'($urandom));

    step("rtype_z1", 2'b10, 3'd1, 3'd0, 3'd3, 3'd0);
    step("rtype_z2", 2'b10, 3'd0, 3'd0, 3'd6, 3'd4);

    // Mid-cycle input changes must not reach the outputs before the next edge.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      drive_rand();
      exp = model(ALUOp, z1, fv, funct, z2);
      @(posedge clk);
      #1 check("random", {illegal, ALUcontrol}, exp);
      #1 drive_rand();
      #1 check("between_edges", {illegal, ALUcontrol}, exp);
    end

    step("pre_async", 2'b10, 3'd0, 3'd0, 3'd7, 3'd0);
    #1 rst_n = 1'b0;
    #1 check("async_reset", {illegal, ALUcontrol}, 4'h2);
    drive(2'b11, 3'd0, 3'd6, 3'd0, 3'd0);
    @(posedge clk);
    #1 check("async_reset_hold", {illegal, ALUcontrol}, 4'h2);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, 3'd0, 3'd0, 3'd0, 3'd0);
    @(posedge clk);
    #1 check("async_release", {illegal, ALUcontrol}, 4'h6);
    step("after_release", 2'b11, 3'd0, 3'd7, 3'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
